mem_port_arbiter: RTL and testbench

//  Shares the single SRAM-like memory port between instruction fetch (IF) and the EX-stage load/store request
//  (ram_req from id_ex). Arbitrates address phases and tracks outstanding transactions in issue order.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_tag_fifo.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and tag type for the memory-port arbiter.
package mem_port_arbiter_pkg;

    // Request source encoding carried in each outstanding-transaction tag
    localparam logic MEM_SRC_INST = 1'b0;
    localparam logic MEM_SRC_DATA = 1'b1;

    // Access size encodings on the bus
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    // One tag per accepted address phase, consumed when its response returns
    typedef struct packed {
        logic src;
        logic discard;
    } mem_tag_t;

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order tag FIFO for outstanding memory transactions.
// Each entry remembers its originator and whether a flush killed it.
module mem_tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  mem_tag_t         push_tag,
    input  logic             pop,
    input  logic             flush_inst,
    output logic [CNT_W-1:0] count,
    output mem_tag_t         head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_tag_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        return p + PTR_W'(1);
    endfunction

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; a flush marks stale fetches before the push lands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (flush_inst) begin
                for (int i = 0; i < DEPTH; i++)
                    if (mem[i].src == MEM_SRC_INST) mem[i].discard <= 1'b1;
            end
            if (push_ok) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and EX load/store.
// Fixed priority to data, owner lock across stalled address phases, in-order
// response routing with flush-killed fetch responses dropped.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic                wr;
        logic [1:0]          size;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W/8-1:0] wstrb;
        logic [DATA_W-1:0]   wdata;
    } bus_pl_t;

    typedef enum logic {LK_IDLE, LK_HELD} lock_state_t;

    lock_state_t      state_q, state_d;
    logic             owner_q, owner_d;
    bus_pl_t          held_q, held_d;
    bus_pl_t          inst_pl, data_pl, grant_pl, bus_pl;
    logic             grant_vld, grant_src;
    logic             push, pop;
    mem_tag_t         push_tag, head;
    logic [CNT_W-1:0] count;
    logic             full, empty;

    // Requester payloads; a fetch is always a plain word read
    always_comb begin
        inst_pl       = '0;
        inst_pl.size  = MEM_SIZE_W;
        inst_pl.addr  = inst_addr;
        data_pl       = '0;
        data_pl.wr    = data_wr;
        data_pl.size  = data_size;
        data_pl.addr  = data_addr;
        data_pl.wstrb = data_wstrb;
        data_pl.wdata = data_wdata;
    end

    // Owner-lock register: the registered payload keeps a stalled request stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LK_IDLE;
            owner_q <= MEM_SRC_INST;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            held_q  <= held_d;
        end
    end

    // Grant selection and lock next-state; a held owner ignores the other side and flush
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        held_d    = held_q;
        grant_vld = 1'b0;
        grant_src = MEM_SRC_INST;
        grant_pl  = '0;
        if (state_q == LK_HELD) begin
            grant_vld = 1'b1;
            grant_src = owner_q;
            grant_pl  = held_q;
        end else if (!full) begin
            if (data_req) begin
                grant_vld = 1'b1;
                grant_src = MEM_SRC_DATA;
                grant_pl  = data_pl;
            end else if (inst_req) begin
                grant_vld = 1'b1;
                grant_src = MEM_SRC_INST;
                grant_pl  = inst_pl;
            end
        end
        if (grant_vld) begin
            if (bus_addr_ok) begin
                state_d = LK_IDLE;
            end else begin
                state_d = LK_HELD;
                owner_d = grant_src;
                held_d  = grant_pl;
            end
        end
    end

    // Bus drive and address hand-back; everything is forced low while in reset
    always_comb begin
        bus_req      = rst_n && grant_vld;
        bus_pl       = bus_req ? grant_pl : '0;
        bus_wr       = bus_pl.wr;
        bus_size     = bus_pl.size;
        bus_addr     = bus_pl.addr;
        bus_wstrb    = bus_pl.wstrb;
        bus_wdata    = bus_pl.wdata;
        push         = bus_req && bus_addr_ok;
        inst_addr_ok = push && (grant_src == MEM_SRC_INST);
        data_addr_ok = push && (grant_src == MEM_SRC_DATA);
        push_tag.src     = grant_src;
        push_tag.discard = (grant_src == MEM_SRC_INST) && flush;
    end

    // Response routing by FIFO head; a flush this cycle also kills a returning fetch
    always_comb begin
        pop          = rst_n && bus_data_ok && !empty;
        data_data_ok = pop && (head.src == MEM_SRC_DATA);
        inst_data_ok = pop && (head.src == MEM_SRC_INST) && !head.discard && !flush;
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
    end

    mem_tag_fifo #(
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_tag   (push_tag),
        .pop        (pop),
        .flush_inst (flush),
        .count      (count),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

`ifndef SYNTHESIS
    // A response with nothing outstanding means the slave broke the protocol
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus_data_ok && (count == '0)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: held-until-accepted requesters, an
// in-order slave with random stalls/latency, and a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int MAX_OUT = 2;
    localparam int NCYC    = 3000;
    localparam int RST_AT  = 1500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    // Expected response per accepted address phase, in issue order
    typedef struct {
        logic        src;   // 1 = data, 0 = fetch
        logic        disc;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] slv_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Slave memory content: a fixed function of the address
    function automatic logic [31:0] resp_of(input logic [31:0] a);
        return (a ^ 32'hDEADBEEF) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: random address stalls, in-order responses at least one cycle after accept
    initial begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                bus_addr_ok = 1'b0;
                bus_data_ok = 1'b0;
            end else begin
                bus_addr_ok = ($urandom_range(0, 99) < 65);
                if (slv_q.size() > 0 && $urandom_range(0, 99) < 55) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = slv_q[0];
                end else begin
                    bus_data_ok = 1'b0;
                    bus_rdata   = $urandom;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                slv_q.delete();
            end else begin
                if (bus_data_ok) void'(slv_q.pop_front());
                if (bus_req && bus_addr_ok) slv_q.push_back(resp_of(bus_addr));
            end
        end
    end

    // Monitor: every response the DUT hands back is compared with the queue head
    initial begin
        exp_t e;
        logic exp_d, exp_i;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (bus_data_ok) begin
                if (exp_q.size() == 0) begin
                    chk1("resp_without_outstanding", 1'b1, 1'b0);
                end else begin
                    e     = exp_q.pop_front();
                    exp_d = e.src;
                    exp_i = !e.src && !e.disc && !flush;
                    chk1("data_data_ok", data_data_ok, exp_d);
                    chk1("inst_data_ok", inst_data_ok, exp_i);
                    if (exp_d) chk("data_rdata", data_rdata, e.rdata);
                    if (exp_i) chk("inst_rdata", inst_rdata, e.rdata);
                end
            end else begin
                chk1("idle_data_data_ok", data_data_ok, 1'b0);
                chk1("idle_inst_data_ok", inst_data_ok, 1'b0);
            end
        end
    end

    // Stimulus plus address-phase reference model
    initial begin
        logic        d_pend, i_pend, m_locked, m_owner;
        logic        g_vld, g_src, acc, stop, in_reset;
        logic [31:0] g_addr;
        exp_t        t;
        d_pend = 1'b0; i_pend = 1'b0; m_locked = 1'b0; m_owner = 1'b0;
        rst_n = 1'b0; flush = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0;
        data_addr = '0; data_wstrb = '0; data_wdata = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            in_reset = (cyc < 3) || (cyc == RST_AT);
            stop     = (cyc >= NCYC - 60);
            rst_n    = !in_reset;
            if (in_reset) begin
                d_pend   = 1'b0;
                i_pend   = 1'b0;
                data_req = 1'b1;
                inst_req = 1'b1;
                flush    = 1'b0;
            end else begin
                if (!d_pend && !stop && $urandom_range(0, 99) < 40) begin
                    d_pend     = 1'b1;
                    data_wr    = $urandom_range(0, 1);
                    data_size  = 2'($urandom_range(0, 2));
                    data_addr  = $urandom;
                    data_wstrb = 4'($urandom);
                    data_wdata = $urandom;
                end
                if (!i_pend && !stop && $urandom_range(0, 99) < 55) begin
                    i_pend    = 1'b1;
                    inst_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                end
                data_req = d_pend;
                inst_req = i_pend;
                flush    = !stop && ($urandom_range(0, 99) < 8);
            end
            #2;
            if (in_reset) begin
                chk1("rst_bus_req", bus_req, 1'b0);
                chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
                chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
                chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
                chk1("rst_data_data_ok", data_data_ok, 1'b0);
                chk("rst_bus_addr", bus_addr, 32'h0);
                exp_q.delete();
                m_locked = 1'b0;
            end else begin
                // Expected winner: held owner, else data over fetch while room remains
                g_vld = 1'b0;
                g_src = 1'b0;
                if (m_locked) begin
                    g_vld = 1'b1;
                    g_src = m_owner;
                end else if (exp_q.size() < MAX_OUT) begin
                    if (data_req) begin g_vld = 1'b1; g_src = 1'b1; end
                    else if (inst_req) begin g_vld = 1'b1; g_src = 1'b0; end
                end
                g_addr = g_src ? data_addr : inst_addr;
                chk1("bus_req", bus_req, g_vld);
                if (g_vld) begin
                    chk("bus_addr", bus_addr, g_addr);
                    chk1("bus_wr", bus_wr, g_src ? data_wr : 1'b0);
                    if (g_src) begin
                        chk("bus_size", 32'(bus_size), 32'(data_size));
                        chk("bus_wstrb", 32'(bus_wstrb), 32'(data_wstrb));
                        chk("bus_wdata", bus_wdata, data_wdata);
                    end
                end
                acc = g_vld && bus_addr_ok;
                chk1("inst_addr_ok", inst_addr_ok, acc && !g_src);
                chk1("data_addr_ok", data_addr_ok, acc && g_src);
                if (flush) begin
                    foreach (exp_q[i]) begin
                        t = exp_q[i];
                        if (!t.src) t.disc = 1'b1;
                        exp_q[i] = t;
                    end
                end
                if (acc) begin
                    t.src   = g_src;
                    t.disc  = !g_src && flush;
                    t.rdata = resp_of(g_addr);
                    exp_q.push_back(t);
                    if (g_src) d_pend = 1'b0;
                    else       i_pend = 1'b0;
                end
                if (g_vld && !bus_addr_ok) begin
                    m_locked = 1'b1;
                    m_owner  = g_src;
                end else begin
                    m_locked = 1'b0;
                end
            end
        end
        chk("drained_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
